cpu_clock_ctrl: RTL and testbench



---
 rtl/cpu_clk_pkg.sv | 9 +
 rtl/button_debounce.sv | 42 ++++
 rtl/cpu_clock_ctrl.sv | 113 +++++++++++
 tb/tb_cpu_clock_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared constants for the CPU clock controller: mode encodings and divide limits.
package cpu_clk_pkg;

  localparam logic MODE_STEP     = 1'b0;
  localparam logic MODE_RUN      = 1'b1;
  localparam int   DIV_MIN       = 2;
  localparam int   DIV_W_DEFAULT = 24;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw switch or button.
module button_debounce #(
  parameter int CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Any cycle that agrees with the accepted level restarts the run.
      if (sync_p1 != level) begin
        if (stable_cnt == CNT_LAST) begin
          level      <= sync_p1;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CNT_ONE;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock controller: run mode with loadable divider, debounced single-step, sticky halt.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_W           = DIV_W_DEFAULT,
  parameter int DIV_DEFAULT     = 6000000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_run,
  input  logic             step_btn,
  input  logic             halt,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             cpu_tick,
  output logic             cpu_clk,
  output logic             halted
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    if (v < DIV_W'(DIV_MIN)) return DIV_W'(DIV_MIN);
    return v;
  endfunction

  logic             mode_db;
  logic             btn_db;
  logic             mode_p1;
  logic             btn_p1;
  logic             mode_chg;
  logic             btn_rise;
  logic             run_mode;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] half_last;

  logic [DIV_W-1:0] div_nxt;
  logic [DIV_W-1:0] cnt_nxt;
  logic             tick_nxt;
  logic             clk_nxt;
  logic             halted_nxt;

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (mode_run),
    .level (mode_db)
  );

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_deb (
    .clk   (clk),
    .rst   (rst),
    .raw   (step_btn),
    .level (btn_db)
  );

  assign mode_chg  = mode_db != mode_p1;
  assign btn_rise  = btn_db & ~btn_p1;
  assign run_mode  = mode_db == MODE_RUN;
  assign div_last  = div_reg - DIV_ONE;
  assign half_last = (div_reg >> 1) - DIV_ONE;

  // Halt outranks load, load outranks a mode change; all three leave cnt, tick and clk at zero.
  always_comb begin
    div_nxt    = div_load ? clamp_div(div_value) : div_reg;
    halted_nxt = halted;
    cnt_nxt    = '0;
    tick_nxt   = 1'b0;
    clk_nxt    = 1'b0;
    if (halt || halted) begin
      halted_nxt = 1'b1;
    end else if (!div_load && !mode_chg) begin
      if (run_mode) begin
        if (cnt == div_last) begin
          tick_nxt = 1'b1;
          clk_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + DIV_ONE;
          clk_nxt = (cnt == half_last) ? 1'b0 : cpu_clk;
        end
      end else begin
        tick_nxt = btn_rise;
        clk_nxt  = btn_db;
      end
    end
  end

  // Stage p1: registered outputs and edge-detect history of the debounced levels
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_p1  <= MODE_STEP;
      btn_p1   <= 1'b0;
      div_reg  <= DIV_RST;
      cnt      <= '0;
      cpu_tick <= 1'b0;
      cpu_clk  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      mode_p1  <= mode_db;
      btn_p1   <= btn_db;
      div_reg  <= div_nxt;
      cnt      <= cnt_nxt;
      cpu_tick <= tick_nxt;
      cpu_clk  <= clk_nxt;
      halted   <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with a cycle-level behavioural model and literal timing checks.
module tb_cpu_clock_ctrl;

  localparam int DW  = 8;
  localparam int DEB = 3;
  localparam int DIV0 = 4;

  logic          clk;
  logic          rst;
  logic          mode_run;
  logic          step_btn;
  logic          halt;
  logic          div_load;
  logic [DW-1:0] div_value;
  logic          cpu_tick;
  logic          cpu_clk;
  logic          halted;

  cpu_clock_ctrl #(.DIV_W(DW), .DIV_DEFAULT(DIV0), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_run  (mode_run),
    .step_btn  (step_btn),
    .halt      (halt),
    .div_load  (div_load),
    .div_value (div_value),
    .cpu_tick  (cpu_tick),
    .cpu_clk   (cpu_clk),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tick_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: index 0 = mode switch, 1 = step button.
  bit m_valid = 0;
  bit h1[2], h2[2], db[2], dbp[2];
  int dis[2];
  int m_div, m_ph;
  bit m_seen, m_tick, m_clk, m_halted;

  always @(posedge clk) begin
    bit raw_in[2];
    bit synced;
    bit cur_mode, prev_mode, cur_btn, prev_btn;
    cyc++;
    raw_in[0] = mode_run;
    raw_in[1] = step_btn;
    if (rst) begin
      m_valid = 1;
      for (int i = 0; i < 2; i++) begin
        h1[i] = 0; h2[i] = 0; db[i] = 0; dbp[i] = 0; dis[i] = 0;
      end
      m_div = DIV0; m_ph = 0; m_seen = 0;
      m_tick = 0; m_clk = 0; m_halted = 0;
    end else begin
      cur_mode = db[0]; prev_mode = dbp[0];
      cur_btn  = db[1]; prev_btn  = dbp[1];
      if (div_load) m_div = (int'(div_value) < 2) ? 2 : int'(div_value);
      if (halt || m_halted) begin
        m_halted = 1; m_tick = 0; m_clk = 0; m_ph = 0; m_seen = 0;
      end else if (div_load || cur_mode != prev_mode) begin
        m_tick = 0; m_clk = 0; m_ph = 0; m_seen = 0;
      end else if (cur_mode) begin
        m_ph++;
        m_tick = (m_ph % m_div) == 0;
        if (m_tick) m_seen = 1;
        m_clk = m_seen && ((m_ph % m_div) < (m_div / 2));
      end else begin
        m_tick = cur_btn && !prev_btn;
        m_clk  = cur_btn;
        m_ph = 0; m_seen = 0;
      end
      for (int i = 0; i < 2; i++) begin
        dbp[i] = db[i];
        synced = h2[i];
        h2[i] = h1[i];
        h1[i] = raw_in[i];
        if (synced != db[i]) begin
          dis[i]++;
          if (dis[i] == DEB) begin
            db[i] = synced;
            dis[i] = 0;
          end
        end else begin
          dis[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_tick", 32'(cpu_tick), 32'(m_tick));
      chk("model_clk", 32'(cpu_clk), 32'(m_clk));
      chk("model_halted", 32'(halted), 32'(m_halted));
      if (cpu_tick) tick_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tick(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (cpu_tick) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0, at, at2, lc, n0, rel, c;
    rst = 1; mode_run = 0; step_btn = 0; halt = 0; div_load = 0; div_value = '0;
    cycles(3);
    chk("rst_tick", 32'(cpu_tick), 0);
    chk("rst_clk", 32'(cpu_clk), 0);
    chk("rst_halted", 32'(halted), 0);
    rst = 0;
    cycles(2);

    // Enter run mode: 6 cycles to debounce + mode change, then 4 more to the first tick.
    mode_run = 1; t0 = cyc;
    wait_tick(30, at);
    chk("run_first_tick", at, t0 + 10);
    chk("run_clk_rise", 32'(cpu_clk), 1);
    cycles(1); chk("run_clk_hi2", 32'(cpu_clk), 1); chk("run_no_tick", 32'(cpu_tick), 0);
    cycles(1); chk("run_clk_lo1", 32'(cpu_clk), 0);
    cycles(1); chk("run_clk_lo2", 32'(cpu_clk), 0);
    cycles(1); chk("run_tick_period4", 32'(cpu_tick), 1);

    // Load divide 7, then divide 0 (clamped to 2).
    cycles(1);
    div_load = 1; div_value = 8'd7; lc = cyc + 1;
    cycles(1); div_load = 0;
    wait_tick(20, at);  chk("load7_first", at, lc + 7);
    wait_tick(20, at2); chk("load7_period", at2 - at, 7);
    cycles(2);
    div_load = 1; div_value = 8'd0; lc = cyc + 1;
    cycles(1); div_load = 0;
    wait_tick(10, at);  chk("load0_first", at, lc + 2);
    wait_tick(10, at2); chk("load0_period", at2 - at, 2);

    // Halt lands on the edge where the next tick is due.
    cycles(1); halt = 1;
    cycles(1); halt = 0;
    chk("halt_suppress_tick", 32'(cpu_tick), 0);
    chk("halt_set", 32'(halted), 1);
    div_load = 1; div_value = 8'd9;
    cycles(1); div_load = 0;
    n0 = tick_cnt;
    cycles(100);
    chk("halt_no_ticks", tick_cnt - n0, 0);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_clk_low", 32'(cpu_clk), 0);
    rst = 1;
    cycles(1);
    rst = 0; rel = cyc;
    chk("rst_clears_halt", 32'(halted), 0);
    wait_tick(30, at);
    chk("post_rst_first_tick", at, rel + 10);

    // Step pulses in run mode leave the cadence untouched.
    n0 = tick_cnt;
    for (int p = 0; p < 5; p++) begin
      step_btn = 1; cycles(4);
      step_btn = 0; cycles(4);
    end
    cycles(8);
    chk("run_ignores_step", tick_cnt - n0, 12);

    // Switch to step mode part-way through a period.
    cycles(1); mode_run = 0;
    cycles(8);
    chk("step_entry_clk", 32'(cpu_clk), 0);
    n0 = tick_cnt;
    cycles(30);
    chk("step_idle_no_ticks", tick_cnt - n0, 0);

    // Press with a two-cycle bounce, then hold.
    step_btn = 1; cycles(1);
    step_btn = 0; cycles(1);
    step_btn = 1; c = cyc;
    wait_tick(20, at);
    chk("step_latency", at, c + 6);
    n0 = tick_cnt;
    cycles(55);
    chk("step_hold_single", tick_cnt - n0, 0);
    chk("step_clk_follows", 32'(cpu_clk), 1);
    step_btn = 0;
    cycles(10);
    chk("step_release_clk", 32'(cpu_clk), 0);

    // Reset mid-period with cpu_clk high after loading divide 7.
    mode_run = 1; t0 = cyc;
    wait_tick(30, at);
    chk("rerun_first_tick", at, t0 + 10);
    div_load = 1; div_value = 8'd7; lc = cyc + 1;
    cycles(1); div_load = 0;
    wait_tick(20, at);
    chk("rerun_load7", at, lc + 7);
    cycles(1);
    chk("pre_rst_clk_high", 32'(cpu_clk), 1);
    rst = 1;
    cycles(1);
    chk("mid_rst_clk", 32'(cpu_clk), 0);
    chk("mid_rst_tick", 32'(cpu_tick), 0);
    rst = 0; rel = cyc;
    wait_tick(30, at);
    chk("mid_rst_step_then_run", at, rel + 10);
    wait_tick(10, at2);
    chk("mid_rst_div_default", at2 - at, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
